mux_arb_nto1: RTL and testbench

- Parametrised N-channel to 1 multiplexer that generalises the combinational 8:1 mux into a registered, handshaked channel selector.
- Each input channel carries a WIDTH-bit word with valid/ready. One channel is granted per cycle by fixed select, fixed priority or round-robin. The word is captured into a single output register with valid/ready backpressure.
- Sits between multiple producers and a single consumer in the datapath.

---
 rtl/mux_arb_nto1.sv | 117 +++++++++++
 tb/tb_mux_arb_nto1.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nto1.sv
// N-channel to 1 registered channel selector with valid/ready on both sides.
// Arbitration by fixed select, fixed priority (lowest index) or round-robin.
module mux_arb_nto1 #(
   parameter  int unsigned N_CH  = 8,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   input  logic [N_CH-1:0]         in_valid,
   output logic [N_CH-1:0]         in_ready,
   input  logic [1:0]              mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        y,
   output logic                    y_valid,
   input  logic                    y_ready,
   output logic [SEL_W-1:0]        y_ch
);

   localparam logic [1:0] MODE_SEL  = 2'b00;
   localparam logic [1:0] MODE_PRIO = 2'b01;
   localparam logic [1:0] MODE_RR   = 2'b10;

   logic             run;
   logic             load_en;
   logic             grant_valid;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_next;
   logic [WIDTH-1:0] grant_word;
   logic             xfer;

   // run keeps in_ready low until the first edge after reset release
   assign load_en = run && (!y_valid || y_ready);
   assign xfer    = load_en && grant_valid;

   // Grant selection; round-robin takes the lowest valid index at or above
   // rr_ptr, falling back to the lowest valid index overall (the wrap).
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      case (mode)
         MODE_SEL: begin
            for (int k = 0; k < int'(N_CH); k++) begin
               if (sel == SEL_W'(k) && in_valid[k]) begin
                  grant_valid = 1'b1;
                  grant       = SEL_W'(k);
               end
            end
         end
         MODE_PRIO: begin
            for (int k = 0; k < int'(N_CH); k++) begin
               if (!grant_valid && in_valid[k]) begin
                  grant_valid = 1'b1;
                  grant       = SEL_W'(k);
               end
            end
         end
         MODE_RR: begin
            for (int k = 0; k < int'(N_CH); k++) begin
               if (!grant_valid && in_valid[k] && SEL_W'(k) >= rr_ptr) begin
                  grant_valid = 1'b1;
                  grant       = SEL_W'(k);
               end
            end
            for (int k = 0; k < int'(N_CH); k++) begin
               if (!grant_valid && in_valid[k]) begin
                  grant_valid = 1'b1;
                  grant       = SEL_W'(k);
               end
            end
         end
         default: begin
            grant_valid = 1'b0;
         end
      endcase
   end

   // Per-channel ready and data mux
   always_comb begin
      in_ready   = '0;
      grant_word = '0;
      for (int k = 0; k < int'(N_CH); k++) begin
         in_ready[k] = xfer && (grant == SEL_W'(k));
         if (grant == SEL_W'(k)) begin
            grant_word = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Wrap at N_CH, not at 2^SEL_W
   assign rr_next = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run     <= 1'b0;
         y       <= '0;
         y_valid <= 1'b0;
         y_ch    <= '0;
         rr_ptr  <= '0;
      end else begin
         run <= 1'b1;
         if (xfer) begin
            y       <= grant_word;
            y_ch    <= grant;
            y_valid <= 1'b1;
            if (mode == MODE_RR) begin
               rr_ptr <= rr_next;
            end
         end else if (y_ready) begin
            y_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: an 8-channel and a 5-channel instance, grant vectors
// from a table, output words checked against a queue of expected words.
module tb_mux_arb_nto1;

   localparam int unsigned NA = 8;
   localparam int unsigned NB = 5;
   localparam int unsigned W  = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NA*W-1:0] a_in_data;
   logic [NA-1:0]   a_in_valid, a_in_ready;
   logic [1:0]      a_mode;
   logic [2:0]      a_sel, a_y_ch;
   logic [W-1:0]    a_y;
   logic            a_y_valid, a_y_ready;

   logic [NB*W-1:0] b_in_data;
   logic [NB-1:0]   b_in_valid, b_in_ready;
   logic [1:0]      b_mode;
   logic [2:0]      b_sel, b_y_ch;
   logic [W-1:0]    b_y;
   logic            b_y_valid, b_y_ready;

   mux_arb_nto1 #(.N_CH(NA), .WIDTH(W)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .y(a_y),
      .y_valid(a_y_valid), .y_ready(a_y_ready), .y_ch(a_y_ch));

   mux_arb_nto1 #(.N_CH(NB), .WIDTH(W)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .y(b_y),
      .y_valid(b_y_valid), .y_ready(b_y_ready), .y_ch(b_y_ch));

   typedef struct packed {
      logic [W-1:0] data;
      logic [2:0]   ch;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      logic [2:0] sel;
      logic [7:0] valid;
      logic [7:0] ready;
   } vec_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   vec_t vecs[10];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int d, input int c);
      exp_t e;
      e.data = W'(d);
      e.ch   = 3'(c);
      return e;
   endfunction

   function automatic int oh2idx(input logic [7:0] v);
      int r = 0;
      for (int k = 0; k < 8; k++) if (v[k]) r = k;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Consumer-side scoreboards: a word is taken at the next edge
   always @(negedge clk) begin
      if (rst_n && a_y_valid && a_y_ready) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_word: got y=%0h ch=%0d expected none", a_y, a_y_ch);
         end else begin
            ea = qa.pop_front();
            check("a_y", {56'd0, a_y}, {56'd0, ea.data});
            check("a_y_ch", {61'd0, a_y_ch}, {61'd0, ea.ch});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_y_valid && b_y_ready) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_word: got y=%0h ch=%0d expected none", b_y, b_y_ch);
         end else begin
            eb = qb.pop_front();
            check("b_y", {56'd0, b_y}, {56'd0, eb.data});
            check("b_y_ch", {61'd0, b_y_ch}, {61'd0, eb.ch});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{2'b00, 3'd3, 8'h08, 8'h08};
      vecs[1] = '{2'b00, 3'd3, 8'hF7, 8'h00};
      vecs[2] = '{2'b00, 3'd0, 8'hFF, 8'h01};
      vecs[3] = '{2'b00, 3'd7, 8'h80, 8'h80};
      vecs[4] = '{2'b01, 3'd0, 8'h94, 8'h04};
      vecs[5] = '{2'b01, 3'd0, 8'h90, 8'h10};
      vecs[6] = '{2'b01, 3'd0, 8'h80, 8'h80};
      vecs[7] = '{2'b01, 3'd0, 8'h00, 8'h00};
      vecs[8] = '{2'b11, 3'd0, 8'hFF, 8'h00};
      vecs[9] = '{2'b01, 3'd5, 8'hFF, 8'h01};

      rst_n = 1'b0;
      for (int k = 0; k < int'(NA); k++) a_in_data[k*W +: W] = W'(8'h30 + k);
      for (int k = 0; k < int'(NB); k++) b_in_data[k*W +: W] = W'(8'h50 + k);
      a_in_data[3*W +: W] = 8'hA5;
      a_mode = 2'b00; a_sel = 3'd3; a_in_valid = 8'h08; a_y_ready = 1'b1;
      b_mode = 2'b01; b_sel = 3'd0; b_in_valid = 5'h1F; b_y_ready = 1'b1;
      tick(); tick();
      check("rst_a_y", {56'd0, a_y}, 64'h0);
      check("rst_a_y_valid", {63'd0, a_y_valid}, 64'h0);
      check("rst_a_in_ready", {56'd0, a_in_ready}, 64'h0);
      check("rst_b_in_ready", {59'd0, b_in_ready}, 64'h0);

      // Fixed select ch3 after release
      rst_n = 1'b1; b_in_valid = '0;
      tick();
      check("fsel_in_ready", {56'd0, a_in_ready}, 64'h08);
      qa.push_back(mk(8'hA5, 3));
      tick();
      check("fsel_y", {56'd0, a_y}, 64'hA5);
      check("fsel_y_ch", {61'd0, a_y_ch}, 64'd3);
      check("fsel_y_valid", {63'd0, a_y_valid}, 64'd1);

      // Reset mid-stream discards the held word
      rst_n = 1'b0;
      qa.delete();
      #1;
      check("midrst_y", {56'd0, a_y}, 64'h0);
      check("midrst_y_valid", {63'd0, a_y_valid}, 64'h0);
      check("midrst_y_ch", {61'd0, a_y_ch}, 64'h0);
      check("midrst_in_ready", {56'd0, a_in_ready}, 64'h0);
      tick();
      a_in_valid = '0; a_in_data[3*W +: W] = 8'h33; rst_n = 1'b1;
      tick();

      // Table of grant vectors, fixed select / priority / hold
      for (int i = 0; i < 10; i++) begin
         a_mode = vecs[i].mode; a_sel = vecs[i].sel; a_in_valid = vecs[i].valid;
         #1;
         check($sformatf("vec%0d_in_ready", i), {56'd0, a_in_ready}, {56'd0, vecs[i].ready});
         if (vecs[i].ready != 8'h00)
            qa.push_back(mk(8'h30 + oh2idx(vecs[i].ready), oh2idx(vecs[i].ready)));
         tick();
      end
      a_in_valid = '0;
      tick();

      // Round-robin across all eight channels with wrap, no bubbles
      a_mode = 2'b10; a_in_valid = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         #1;
         check($sformatf("rr8_%0d_in_ready", i), {56'd0, a_in_ready}, {56'd0, NA'(1) << (i % 8)});
         if (i > 0) check($sformatf("rr8_%0d_y_valid", i), {63'd0, a_y_valid}, 64'd1);
         qa.push_back(mk(8'h30 + (i % 8), i % 8));
         tick();
      end
      a_in_valid = '0;
      tick();

      // Backpressure: 0x11 held three cycles while ch1 waits with 0x22
      a_in_data[0*W +: W] = 8'h11; a_in_data[1*W +: W] = 8'h22;
      a_mode = 2'b00; a_sel = 3'd0; a_in_valid = 8'h01; a_y_ready = 1'b0;
      #1;
      check("bp_load_in_ready", {56'd0, a_in_ready}, 64'h01);
      qa.push_back(mk(8'h11, 0));
      tick();
      a_sel = 3'd1; a_in_valid = 8'h02;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp%0d_in_ready", i), {56'd0, a_in_ready}, 64'h0);
         check($sformatf("bp%0d_y", i), {56'd0, a_y}, 64'h11);
         check($sformatf("bp%0d_y_valid", i), {63'd0, a_y_valid}, 64'd1);
         tick();
      end
      a_y_ready = 1'b1;
      #1;
      check("bp_release_in_ready", {56'd0, a_in_ready}, 64'h02);
      qa.push_back(mk(8'h22, 1));
      tick();
      check("bp_next_y", {56'd0, a_y}, 64'h22);
      check("bp_next_y_ch", {61'd0, a_y_ch}, 64'd1);
      check("bp_next_y_valid", {63'd0, a_y_valid}, 64'd1);
      a_in_valid = '0;
      tick();
      check("drain_y_valid", {63'd0, a_y_valid}, 64'd0);
      check("drain_y_held", {56'd0, a_y}, 64'h22);

      // Five channels: round-robin wraps 4 -> 0
      b_mode = 2'b10; b_in_valid = 5'h1F;
      for (int i = 0; i < 7; i++) begin
         #1;
         check($sformatf("rr5_%0d_in_ready", i), {59'd0, b_in_ready}, {59'd0, NB'(1) << (i % 5)});
         qb.push_back(mk(8'h50 + (i % 5), i % 5));
         tick();
      end
      // sel beyond N_CH grants nothing
      b_mode = 2'b00; b_sel = 3'd6;
      #1;
      check("bsel6_in_ready", {59'd0, b_in_ready}, 64'h0);
      tick();
      check("bsel6_y_valid", {63'd0, b_y_valid}, 64'd0);
      b_mode = 2'b11;
      #1;
      check("bhold_in_ready", {59'd0, b_in_ready}, 64'h0);
      tick();
      check("bhold_y_valid", {63'd0, b_y_valid}, 64'd0);
      b_mode = 2'b00; b_sel = 3'd4;
      #1;
      check("bsel4_in_ready", {59'd0, b_in_ready}, 64'h10);
      qb.push_back(mk(8'h54, 4));
      tick();
      // Round-robin resumes at ch2 (pointer untouched by other modes)
      b_mode = 2'b10;
      #1;
      check("bresume_in_ready", {59'd0, b_in_ready}, 64'h04);
      qb.push_back(mk(8'h52, 2));
      tick();
      #1;
      check("bnext_in_ready", {59'd0, b_in_ready}, 64'h08);
      qb.push_back(mk(8'h53, 3));
      tick();
      b_in_valid = 5'h01;
      #1;
      check("bwrapsearch_in_ready", {59'd0, b_in_ready}, 64'h01);
      qb.push_back(mk(8'h50, 0));
      tick();
      b_in_valid = '0;
      tick(); tick();

      check("qa_empty", 64'(qa.size()), 64'd0);
      check("qb_empty", 64'(qb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
